// File: rtl/dpm_feed_fifo.sv
// rtl/dpm_feed_fifo.sv - FWFT row FIFO feeding the DPM with group-start sequencing
// Occupancy counter disambiguates full/empty; group FSM paces the DPM in GROUP_ROWS chunks.
module dpm_feed_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int GROUP_ROWS = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              flush,
  input  logic              bypass_mode,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_data_valid,
  input  logic              fifo_pop,
  output logic              group_start,
  output logic [CNT_W-1:0]  count,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PL_W  = $clog2(GROUP_ROWS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PL_W-1:0]   pops_left_q, pops_left_d;
  state_t            state_q, state_d;
  logic              group_start_q, group_start_d;
  logic              underflow_q, underflow_d;
  logic              full, do_write, do_pop;

  assign full            = (count_q == CNT_W'(DEPTH));
  assign wr_ready        = bypass_mode || !full;
  assign fifo_data_valid = (count_q != '0);
  assign fifo_data       = mem_q[rd_ptr_q];
  assign count           = count_q;
  assign group_start     = group_start_q;
  assign underflow       = underflow_q;

  // Bypass completes the handshake but never touches storage.
  assign do_write = wr_valid && wr_ready && !bypass_mode && !flush;
  assign do_pop   = fifo_pop && fifo_data_valid && !flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pops_left_d   = pops_left_q;
    state_d       = state_q;
    group_start_d = 1'b0;
    underflow_d   = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pops_left_d = '0;
      state_d     = IDLE;
      underflow_d = 1'b0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (fifo_pop && !fifo_data_valid) underflow_d = 1'b1;

      case ({do_write, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Group launch looks at registered occupancy, so it lags the filling write by one edge.
      case (state_q)
        IDLE: begin
          if (!bypass_mode && (count_q >= CNT_W'(GROUP_ROWS))) begin
            state_d       = BUSY;
            group_start_d = 1'b1;
            pops_left_d   = PL_W'(GROUP_ROWS);
          end
        end
        BUSY: begin
          if (do_pop) begin
            pops_left_d = pops_left_q - PL_W'(1);
            if (pops_left_q == PL_W'(1)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pops_left_q   <= '0;
      state_q       <= IDLE;
      group_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pops_left_q   <= pops_left_d;
      state_q       <= state_d;
      group_start_q <= group_start_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage is left uninitialised; flush and reset only move the pointers.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_dpm_feed_fifo.sv
// tb/tb_dpm_feed_fifo.sv - directed self-checking bench for dpm_feed_fifo
module tb_dpm_feed_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        flush;
  logic        bypass_mode;
  logic [15:0] fifo_data;
  logic        fifo_data_valid;
  logic        fifo_pop;
  logic        group_start;
  logic [4:0]  count;
  logic        underflow;

  int total = 0;
  int bad   = 0;
  int gs_cnt = 0;
  int gs_base;

  always #5 clk = ~clk;

  dpm_feed_fifo #(.DATA_W(16), .DEPTH(16), .GROUP_ROWS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .flush           (flush),
    .bypass_mode     (bypass_mode),
    .fifo_data       (fifo_data),
    .fifo_data_valid (fifo_data_valid),
    .fifo_pop        (fifo_pop),
    .group_start     (group_start),
    .count           (count),
    .underflow       (underflow)
  );

  always @(negedge clk) if (group_start === 1'b1) gs_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_data = '0; wr_valid = 1'b0; flush = 1'b0;
    bypass_mode = 1'b0; fifo_pop = 1'b0;
    tick(); tick();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(fifo_data_valid), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_gs", 32'(group_start), 0);
    check("rst_underflow", 32'(underflow), 0);
    rst_n = 1'b1;
    tick();

    // Four writes; group_start one edge after count hits 4
    gs_base = gs_cnt;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 16'(i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    check("w4_count", 32'(count), 4);
    check("w4_gs_early", 32'(group_start), 0);
    tick();
    check("w4_gs_pulse", 32'(group_start), 1);
    check("w4_head", 32'(fifo_data), 16'h0001);
    tick();
    check("w4_gs_drop", 32'(group_start), 0);
    check("w4_gs_once", 32'(gs_cnt - gs_base), 1);

    // Gapped pops
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("gap_pop%0d", i), 32'(fifo_data), 32'(i));
      fifo_pop = 1'b1; tick();
      fifo_pop = 1'b0; tick(); tick();
    end
    check("gap_count", 32'(count), 0);
    check("gap_valid", 32'(fifo_data_valid), 0);
    check("gap_no_regs", 32'(gs_cnt - gs_base), 1);

    // Fill to full with pointers starting at 4 so storage wraps
    gs_base = gs_cnt;
    wr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wr_data = 16'h0100 + 16'(k + 1);
      check($sformatf("fill_ready%0d", k), 32'(wr_ready), 1);
      tick();
    end
    check("full_count", 32'(count), 16);
    check("full_ready", 32'(wr_ready), 0);
    check("fill_gs_once", 32'(gs_cnt - gs_base), 1);
    wr_data = 16'h0111;
    tick();
    check("held_count", 32'(count), 16);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("free_count", 32'(count), 15);
    check("free_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    check("17th_count", 32'(count), 16);
    fifo_pop = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      check($sformatf("wrap_pop%0d", k), 32'(fifo_data), 32'h0100 + 32'(k));
      tick();
    end
    fifo_pop = 1'b0;
    check("drain_count", 32'(count), 0);

    // Simultaneous write and pop at count 5
    wr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wr_data = 16'h0200 + 16'(k);
      tick();
    end
    check("c5_count", 32'(count), 5);
    wr_data = 16'h0205; fifo_pop = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("wp5_count", 32'(count), 5);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("wp5_pop%0d", k), 32'(fifo_data), 32'h0200 + 32'(k));
      tick();
    end
    fifo_pop = 1'b0;
    check("wp5_drain", 32'(count), 0);
    check("wp5_no_uf", 32'(underflow), 0);

    // Simultaneous write and pop while empty
    wr_data = 16'h0300; wr_valid = 1'b1; fifo_pop = 1'b1;
    tick();
    wr_valid = 1'b0; fifo_pop = 1'b0;
    check("wp0_underflow", 32'(underflow), 1);
    check("wp0_count", 32'(count), 1);
    check("wp0_head", 32'(fifo_data), 16'h0300);
    fifo_pop = 1'b1; tick(); fifo_pop = 1'b0;
    check("uf_sticky", 32'(underflow), 1);
    check("uf_count", 32'(count), 0);

    // Bypass
    gs_base = gs_cnt;
    bypass_mode = 1'b1; wr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_data = 16'h0a00 + 16'(k);
      check($sformatf("byp_ready%0d", k), 32'(wr_ready), 1);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    check("byp_count", 32'(count), 0);
    check("byp_valid", 32'(fifo_data_valid), 0);
    check("byp_no_gs", 32'(gs_cnt - gs_base), 0);
    bypass_mode = 1'b0;

    // Flush while BUSY with count 6 and a colliding write
    gs_base = gs_cnt;
    wr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_data = 16'h0400 + 16'(k);
      tick();
    end
    check("pre_flush_count", 32'(count), 6);
    check("pre_flush_gs", 32'(gs_cnt - gs_base), 1);
    wr_data = 16'h04ff; flush = 1'b1;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(fifo_data_valid), 0);
    check("flush_uf", 32'(underflow), 0);
    check("flush_gs", 32'(group_start), 0);
    fifo_pop = 1'b1; tick(); fifo_pop = 1'b0;
    check("post_flush_uf", 32'(underflow), 1);

    // A fresh group after flush shows the FSM is back in IDLE
    wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_data = 16'h0500 + 16'(k);
      tick();
    end
    wr_valid = 1'b1; wr_data = 16'h0504;
    tick();
    check("regroup_gs", 32'(group_start), 1);
    check("regroup_head", 32'(fifo_data), 16'h0500);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(fifo_data_valid), 0);
    check("arst_ready", 32'(wr_ready), 1);
    check("arst_gs", 32'(group_start), 0);
    check("arst_uf", 32'(underflow), 0);
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpm_feed_fifo.md
# dpm_feed_fifo

First-word-fall-through row FIFO that sits directly upstream of the DPM (deformable processing module). It buffers samples from the offset/feature producer and presents the head entry on `fifo_data`/`fifo_data_valid`, advancing on the DPM's `fifo_pop`. It also issues a one-cycle `group_start` to the DPM whenever a full group of `GROUP_ROWS` entries is buffered and no group is outstanding. It handles bypass mode, flush and underflow reporting.

## Interface
- `DATA_W`, 16, sample width.
- `DEPTH`, 16, entries; power of two, ≥ `GROUP_ROWS`.
- `GROUP_ROWS`, 4, entries consumed by the DPM per group; ≥ 1.
- `CNT_W`, `$clog2(DEPTH+1)`, width of `count`. Derived; do not override.

- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_data`  in  `DATA_W`  producer sample.
- `wr_valid`  in  1  producer sample valid.
- `wr_ready`  out  1  FIFO can accept; a write occurs when `wr_valid && wr_ready`.
- `flush`  in  1  synchronous clear of contents and group state.
- `bypass_mode`  in  1  DPM bypassed: writes are accepted and discarded, and `group_start` is suppressed.
- `fifo_data`  out  `DATA_W`  head entry (FWFT).
- `fifo_data_valid`  out  1  FIFO non-empty.
- `fifo_pop`  in  1  consume head entry.
- `group_start`  out  1  one-cycle pulse: a group is ready for the DPM.
- `count`  out  `CNT_W`  current occupancy.
- `underflow`  out  1  sticky; pop seen while empty.

## Operation
- Storage: `DEPTH`-entry register array.
  - `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap naturally at `DEPTH`.
  - A separate occupancy counter `count` disambiguates full from empty.
- `wr_ready = !full`, where `full = (count == DEPTH)`. It is registered-state based and does not combinationally depend on `fifo_pop`.
- A write stores `wr_data` at `wr_ptr` and increments `wr_ptr`.
  - In `bypass_mode` the write handshake completes but nothing is stored and pointers/count are unchanged. `wr_ready = 1` in bypass.
- Pop when `fifo_pop && fifo_data_valid`: increment `rd_ptr`.
- Pop when `fifo_pop && !fifo_data_valid`: ignored, `underflow` set to 1. It stays set until reset or flush.
- Simultaneous valid write and valid pop: `count` unchanged, both pointers advance.
  - When `count == 0`, a same-cycle write plus pop is an underflow: the pop is ignored and the write is stored.
- `fifo_data = mem[rd_ptr]` combinationally. It is don't-care when `fifo_data_valid = 0`.
- Group state machine, states IDLE and BUSY, with `pops_left` counter of `$clog2(GROUP_ROWS+1)` bits:
  - IDLE → BUSY when `!bypass_mode && !flush && count ≥ GROUP_ROWS`, evaluated on registered `count`.
    - On that edge `group_start` is registered 1 for exactly one cycle, and `pops_left` is loaded with `GROUP_ROWS`.
  - BUSY: each valid pop decrements `pops_left`. The pop that takes it from 1 to 0 returns the FSM to IDLE on that edge.
  - IDLE can re-issue `group_start` no earlier than the cycle after returning to IDLE.
  - `bypass_mode` asserted while BUSY: the FSM stays BUSY until the pops complete or a flush occurs.
- Flush, which has priority over a same-cycle write, pop and group transition:
  - `wr_ptr`, `rd_ptr`, `count` ← 0.
  - FSM ← IDLE, `pops_left` ← 0.
  - `group_start` ← 0, `underflow` ← 0.
  - The array contents are not cleared.
- Reset values: `count = 0`, `fifo_data_valid = 0`, `wr_ready = 1`, `group_start = 0`, `underflow = 0`, FSM IDLE, pointers 0. `fifo_data` is unspecified.

## Timing
- Write latency: a write accepted at edge N into an empty FIFO gives `fifo_data_valid = 1` and `fifo_data` = sample after edge N.
- A pop at edge N exposes the next entry after edge N. Back-to-back pops every cycle are supported.
- `group_start` rises one edge after `count` first reaches `GROUP_ROWS`.
  - Example: the 4th write is accepted at edge N, `count = 4` after N, and `group_start = 1` after N+1 for one cycle.
- The DPM registers its pop, so the first pop of a group arrives ≥ 2 cycles after `group_start`. The FIFO tolerates any gap between pops.
- The full → not-full transition of `wr_ready` is visible the cycle after the freeing pop; there is no same-cycle write-through when full.

## Test plan
- Reset, then write 0x0001..0x0004 on consecutive cycles.
  - Required: `count = 4`, exactly one `group_start` pulse after the 4th write + 1 cycle, `fifo_data = 0x0001`.
- Pop 4 entries with a 2-cycle gap between pops.
  - Required: `fifo_data` reads 1, 2, 3, 4; FSM returns to IDLE after the 4th pop; no second `group_start` while `count < 4`.
- Fill to 16 entries with continuous `wr_valid`.
  - Required: `wr_ready = 0` at `count = 16`, the 17th sample is held off.
  - Then one pop: `wr_ready = 1` next cycle, the 17th sample is stored, and pointer wrap preserves order.
- Simultaneous write and pop at `count = 5`: `count` stays 5 and data order is intact.
  - Simultaneous write and pop at `count = 0`: `underflow = 1`, `count = 1`.
- `bypass_mode = 1` with 8 writes.
  - Required: all accepted, `count = 0`, `fifo_data_valid = 0`, no `group_start`.
- `flush` asserted in BUSY with `count = 6` and a same-cycle write.
  - Required: `count = 0`, FSM IDLE, `underflow = 0`, write dropped.
  - `rst_n` low mid-stream: all outputs return to reset values asynchronously.
